// File: rtl/door_idol_controller.sv
`default_nettype none
// ============================================================================
// Module      : door_idol_controller
// Description : Per-level door/idol tile controller. Walks the door through
//               HIDDEN -> LOCKED -> OPEN -> IDOL -> COLLECTED, and produces the
//               registered rectangle hit, tile offsets and bitmap select for
//               the downstream door/idol bitmap stage.
//               Optional build macro DOOR_IDOL_BLINK_EN makes the idol blink
//               during the final BLINK_FRAMES frames of its timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module door_idol_controller #(
  parameter logic [10:0] DOOR_X       = 11'd288,
  parameter logic [10:0] DOOR_Y       = 11'd224,
  parameter int          TILE_SIZE    = 32,
  parameter int          IDOL_TIMEOUT = 600
`ifdef DOOR_IDOL_BLINK_EN
  ,
  parameter int          BLINK_FRAMES = 120
`endif
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        mode_sel,
  input  logic        brickDestroyed,
  input  logic [3:0]  enemiesLeft,
  input  logic        playerCollision,
  input  logic        levelRestart,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        select,
  output logic        doorOpen,
  output logic        levelComplete
);

  // Tile edges are formed at 12 bits so DOOR_X/Y near the top of the 11-bit
  // range cannot wrap the exclusive right/bottom bound.
  localparam logic [11:0] c_X_END        = {1'b0, DOOR_X} + 12'(TILE_SIZE);
  localparam logic [11:0] c_Y_END        = {1'b0, DOOR_Y} + 12'(TILE_SIZE);
  localparam logic [9:0]  c_TIMEOUT_LAST = 10'(IDOL_TIMEOUT - 1);
  localparam logic [9:0]  c_CNT_MAX      = 10'h3FF;
`ifdef DOOR_IDOL_BLINK_EN
  localparam logic [9:0]  c_BLINK_START  = 10'(IDOL_TIMEOUT - BLINK_FRAMES);
`endif

  typedef enum logic [2:0] {
    S_HIDDEN    = 3'd0,
    S_LOCKED    = 3'd1,
    S_OPEN      = 3'd2,
    S_IDOL      = 3'd3,
    S_COLLECTED = 3'd4
  } t_state;

  t_state      r_state;
  logic [9:0]  r_frame_cnt;
  logic        r_blink;
  logic [10:0] r_offset_x;
  logic [10:0] r_offset_y;
  logic        r_inside;
  logic        r_select;
  logic        r_door_open;
  logic        r_level_complete;

  logic        w_hit;
  logic        w_visible;
  logic        w_show;
  logic        w_timeout;

  // Geometric hit test and tile visibility for the current state
  always_comb begin
    w_hit = ({1'b0, pixelX} >= {1'b0, DOOR_X}) && ({1'b0, pixelX} < c_X_END) &&
            ({1'b0, pixelY} >= {1'b0, DOOR_Y}) && ({1'b0, pixelY} < c_Y_END);
    w_visible = (r_state == S_LOCKED) || (r_state == S_OPEN) || (r_state == S_IDOL);
    w_timeout = startOfFrame && (r_frame_cnt == c_TIMEOUT_LAST);
`ifdef DOOR_IDOL_BLINK_EN
    w_show = w_hit && w_visible && !mode_sel && !r_blink;
`else
    w_show = w_hit && w_visible && !mode_sel;
`endif
  end

  // Door lifecycle FSM, idol frame counter and registered pixel outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= S_HIDDEN;
      r_frame_cnt      <= '0;
      r_blink          <= 1'b0;
      r_offset_x       <= '0;
      r_offset_y       <= '0;
      r_inside         <= 1'b0;
      r_select         <= 1'b0;
      r_door_open      <= 1'b0;
      r_level_complete <= 1'b0;
    end else begin
      // Pixel-path outputs reflect the state held during this cycle.
      r_inside         <= w_show;
      r_offset_x       <= w_hit ? (pixelX - DOOR_X) : '0;
      r_offset_y       <= w_hit ? (pixelY - DOOR_Y) : '0;
      r_select         <= (r_state == S_IDOL) && !mode_sel;
      r_door_open      <= (r_state == S_OPEN) && !mode_sel;
      r_level_complete <= 1'b0;

      if (r_state != S_IDOL) begin
        r_blink <= 1'b0;
      end

      if (levelRestart || mode_sel) begin
        r_state     <= S_HIDDEN;
        r_frame_cnt <= '0;
        r_blink     <= 1'b0;
      end else begin
        case (r_state)
          S_HIDDEN: begin
            if (brickDestroyed) begin
              r_state <= S_LOCKED;
            end
          end
          S_LOCKED: begin
            if (enemiesLeft == 4'd0) begin
              r_state <= S_OPEN;
            end
          end
          S_OPEN: begin
            if (playerCollision) begin
              r_state     <= S_IDOL;
              r_frame_cnt <= '0;
            end
          end
          S_IDOL: begin
            // Collision beats a coincident timeout.
            if (playerCollision) begin
              r_state          <= S_COLLECTED;
              r_level_complete <= 1'b1;
              r_blink          <= 1'b0;
            end else if (w_timeout) begin
              r_state     <= S_OPEN;
              r_frame_cnt <= '0;
              r_blink     <= 1'b0;
            end else if (startOfFrame) begin
              if (r_frame_cnt != c_CNT_MAX) begin
                r_frame_cnt <= r_frame_cnt + 10'd1;
              end
`ifdef DOOR_IDOL_BLINK_EN
              if (r_frame_cnt >= c_BLINK_START) begin
                r_blink <= !r_blink;
              end
`endif
            end
          end
          S_COLLECTED: begin
            r_state <= S_COLLECTED;
          end
          default: begin
            r_state     <= S_HIDDEN;
            r_frame_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign offsetX         = r_offset_x;
  assign offsetY         = r_offset_y;
  assign InsideRectangle = r_inside;
  assign select          = r_select;
  assign doorOpen        = r_door_open;
  assign levelComplete   = r_level_complete;

endmodule
`default_nettype wire

// File: tb/tb_door_idol_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_door_idol_controller
// Description : Directed self-checking bench for door_idol_controller.
//               Expected output sets are queued as each stimulus cycle is
//               driven and compared when the registered outputs appear.
//               Honours DOOR_IDOL_BLINK_EN for the idol-timeout expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_door_idol_controller;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        mode_sel;
  logic        brickDestroyed;
  logic [3:0]  enemiesLeft;
  logic        playerCollision;
  logic        levelRestart;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        select;
  logic        doorOpen;
  logic        levelComplete;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
    logic        sel;
    logic        opn;
    logic        lc;
  } exp_t;

  exp_t sb[$];

  door_idol_controller dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .mode_sel        (mode_sel),
    .brickDestroyed  (brickDestroyed),
    .enemiesLeft     (enemiesLeft),
    .playerCollision (playerCollision),
    .levelRestart    (levelRestart),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .select          (select),
    .doorOpen        (doorOpen),
    .levelComplete   (levelComplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Pop one expected set and compare it against the outputs now visible.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".inside"}, {10'd0, InsideRectangle}, {10'd0, e.ins});
      chk({e.tag, ".offX"},   offsetX,                  e.ox);
      chk({e.tag, ".offY"},   offsetY,                  e.oy);
      chk({e.tag, ".select"}, {10'd0, select},          {10'd0, e.sel});
      chk({e.tag, ".open"},   {10'd0, doorOpen},        {10'd0, e.opn});
      chk({e.tag, ".lvlc"},   {10'd0, levelComplete},   {10'd0, e.lc});
    end
  endtask

  // Queue the expectation for the inputs currently driven, clock once, check.
  task automatic step(input string tag, input logic ins, input logic [10:0] ox,
                      input logic [10:0] oy, input logic sel, input logic opn,
                      input logic lc);
    exp_t e;
    e.tag = tag; e.ins = ins; e.ox = ox; e.oy = oy;
    e.sel = sel; e.opn = opn; e.lc = lc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  logic blink_m;
  logic exp_ins;

  initial begin
    resetN          = 1'b0;
    startOfFrame    = 1'b0;
    pixelX          = 11'd300;
    pixelY          = 11'd230;
    mode_sel        = 1'b0;
    brickDestroyed  = 1'b0;
    enemiesLeft     = 4'd3;
    playerCollision = 1'b0;
    levelRestart    = 1'b0;
    blink_m         = 1'b0;

    idle();
    step("reset", 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;

    // HIDDEN: tile invisible even though the pixel is inside it
    step("hidden", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b1;
    step("brick", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b0;
    step("locked", 1'b1, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);

    // Rectangle edges while visible
    pixelX = 11'd319; pixelY = 11'd224;
    step("edge_r_in", 1'b1, 11'd31, 11'd0, 1'b0, 1'b0, 1'b0);
    pixelX = 11'd320; pixelY = 11'd224;
    step("edge_r_out", 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    pixelX = 11'd288; pixelY = 11'd256;
    step("edge_b_out", 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    pixelX = 11'd288; pixelY = 11'd255;
    step("edge_b_in", 1'b1, 11'd0, 11'd31, 1'b0, 1'b0, 1'b0);
    pixelX = 11'd287; pixelY = 11'd230;
    step("edge_l_out", 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0);

    // Enemies cleared -> OPEN, collision -> IDOL, collision -> COLLECTED
    pixelX = 11'd300; pixelY = 11'd230;
    enemiesLeft = 4'd0;
    step("enemies0", 1'b1, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    step("open", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    playerCollision = 1'b1;
    step("grab_door", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    playerCollision = 1'b0;
    step("idol", 1'b1, 11'd12, 11'd6, 1'b1, 1'b0, 1'b0);
    playerCollision = 1'b1;
    step("collect", 1'b1, 11'd12, 11'd6, 1'b1, 1'b0, 1'b1);
    playerCollision = 1'b0;
    step("collected", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    step("no_repeat", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    playerCollision = 1'b1;
    step("coll_drop", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    playerCollision = 1'b0;

    // Restart, then brick with enemies already zero: LOCKED for one cycle
    levelRestart = 1'b1;
    step("restart", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    levelRestart = 1'b0;
    playerCollision = 1'b1;
    step("hid_coll_drop", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    playerCollision = 1'b0;
    brickDestroyed = 1'b1;
    step("brick2", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b0;
    step("locked2", 1'b1, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    step("open2", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    playerCollision = 1'b1;
    step("grab2", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    playerCollision = 1'b0;

    // Idol timeout: 600 frame pulses return the door to OPEN
    blink_m = 1'b0;
    for (int k = 0; k < 600; k++) begin
      startOfFrame = 1'b1;
`ifdef DOOR_IDOL_BLINK_EN
      exp_ins = !blink_m;
`else
      exp_ins = 1'b1;
`endif
      step("idol_frame", exp_ins, 11'd12, 11'd6, 1'b1, 1'b0, 1'b0);
      if (k == 599)      blink_m = 1'b0;
      else if (k >= 480) blink_m = !blink_m;
    end
    startOfFrame = 1'b0;
    step("timeout_open", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);

    // Collision coincident with the 600th frame pulse wins
    playerCollision = 1'b1;
    step("grab3", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    playerCollision = 1'b0;
    step("idol3", 1'b1, 11'd12, 11'd6, 1'b1, 1'b0, 1'b0);
    blink_m = 1'b0;
    for (int k = 0; k < 599; k++) begin
      startOfFrame = 1'b1;
      idle();
      if (k >= 480) blink_m = !blink_m;
    end
`ifdef DOOR_IDOL_BLINK_EN
    exp_ins = !blink_m;
`else
    exp_ins = 1'b1;
`endif
    playerCollision = 1'b1;
    step("coll_at_timeout", exp_ins, 11'd12, 11'd6, 1'b1, 1'b0, 1'b1);
    startOfFrame = 1'b0;
    playerCollision = 1'b0;
    step("collected3", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);

    // mode_sel in OPEN forces HIDDEN and holds it
    levelRestart = 1'b1;
    step("restart2", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    levelRestart = 1'b0;
    brickDestroyed = 1'b1;
    step("brick4", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b0;
    step("locked4", 1'b1, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    step("open4", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    mode_sel = 1'b1;
    step("vs_mode", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b1;
    step("vs_brick", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b0;
    mode_sel = 1'b0;
    step("vs_exit", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    step("vs_hidden", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);

    // levelRestart beats a coincident collision in OPEN
    brickDestroyed = 1'b1;
    step("brick5", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    brickDestroyed = 1'b0;
    step("locked5", 1'b1, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);
    levelRestart = 1'b1;
    playerCollision = 1'b1;
    step("restart_prio", 1'b1, 11'd12, 11'd6, 1'b0, 1'b1, 1'b0);
    levelRestart = 1'b0;
    playerCollision = 1'b0;
    step("after_prio", 1'b0, 11'd12, 11'd6, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
